// File: rtl/multu_seq_ctrl.sv
// rtl/multu_seq_ctrl.sv - sequential unsigned multiply unit with Hi/Lo registers and pipeline interlock
// Define MULTU_ZERO_SKIP_EN to finish zero-operand multiplies in a single edge.
module multu_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hilo_rd,
  input  logic             flush,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod_shift;
  logic                 accept;
  logic                 zero_op;

`ifdef MULTU_ZERO_SKIP_EN
  assign zero_op = (op_a == '0) || (op_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign accept = start & ~flush;

  // Carry out of the add lands in the top bit after the right shift.
  always_comb begin
    sum        = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_shift = {sum, prod_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          if (zero_op) begin
            state_d = DONE;
            hi_d    = '0;
            lo_d    = '0;
          end else begin
            state_d = RUN;
            mcand_d = op_a;
            prod_d  = {{WIDTH{1'b0}}, op_b};
            cnt_d   = '0;
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          prod_d = prod_shift;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            hi_d    = prod_shift[2*WIDTH-1:WIDTH];
            lo_d    = prod_shift[WIDTH-1:0];
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // DONE is deliberately not stalled so an mfhi/mflo there sees the new result.
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign stall_req = busy & (start | hilo_rd);
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;

endmodule

// File: tb/tb_multu_seq_ctrl.sv
// tb/tb_multu_seq_ctrl.sv - scoreboard bench for multu_seq_ctrl against an arithmetic reference model
module tb_multu_seq_ctrl;

  localparam int W = 32;

`ifdef MULTU_ZERO_SKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         hilo_rd = 1'b0;
  logic         flush = 1'b0;
  logic         busy, stall_req, done;
  logic [W-1:0] hi_out, lo_out;

  multu_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .hilo_rd(hilo_rd), .flush(flush), .busy(busy), .stall_req(stall_req),
    .done(done), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [63:0] prod;
    int          issue;
    int          lat;
  } exp_t;
  exp_t sb[$];

  // Reference model: edges left in the multiply, whether a result was just produced,
  // and the architectural Hi/Lo, all from the behavioural rules.
  int           cyc = 0;
  int           rem = 0;
  bit           m_done = 1'b0;
  logic [W-1:0] ma = '0, mb = '0, mhi = '0, mlo = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem = 0; m_done = 1'b0; mhi = '0; mlo = '0;
      sb.delete();
    end else begin
      cyc++;
      if (rem > 0) begin
        if (flush) begin
          rem = 0;
          if (sb.size() > 0) sb.delete(sb.size() - 1);
        end else begin
          rem--;
          if (rem == 0) begin
            {mhi, mlo} = 64'(ma) * 64'(mb);
            m_done = 1'b1;
          end
        end
      end else begin
        m_done = 1'b0;
        if (start && !flush) begin
          ma = op_a; mb = op_b;
          if (ZSKIP && (op_a == 0 || op_b == 0)) begin
            mhi = '0; mlo = '0; m_done = 1'b1;
            sb.push_back('{prod: 64'd0, issue: cyc, lat: 0});
          end else begin
            rem = W;
            sb.push_back('{prod: 64'(op_a) * 64'(op_b), issue: cyc, lat: W});
          end
        end
      end
    end
  end

  // Monitor: per-cycle outputs versus model, and a scoreboard pop on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    chk("cycle {busy,done,stall,hi,lo}",
        {13'd0, busy, done, stall_req, hi_out, lo_out},
        {13'd0, rem > 0, m_done, (rem > 0) && (start || hilo_rd), mhi, mlo});
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 80'd1, 80'd0);
      end else begin
        e = sb.pop_front();
        chk("result", {16'd0, hi_out, lo_out}, {16'd0, e.prod});
        chk("latency", 80'(cyc - e.issue), 80'(e.lat));
      end
    end
  end

  task automatic step(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic h, input logic f);
    @(posedge clk); #2;
    start = s; op_a = a; op_b = b; hilo_rd = h; flush = f;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic wait_done(input logic h, output int n);
    n = 0;
    do begin
      step(1'b0, '0, '0, h, 1'b0);
      n++;
    end while (!done && n < 200);
    chk("wait_done_timeout", {79'd0, done}, 80'd1);
  endtask

  initial begin
    int n;
    #100000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [W-1:0] a, b;
    logic [63:0] p;

    #1;
    chk("reset_outputs", {13'd0, busy, done, stall_req, hi_out, lo_out}, 80'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    idle(2);

    // Basic 3*5
    step(1'b1, 32'd3, 32'd5, 1'b0, 1'b0);
    wait_done(1'b0, n);
    chk("basic_latency_steps", 80'(n), 80'(W + 1));
    chk("basic_hilo", {16'd0, hi_out, lo_out}, {16'd0, 32'd0, 32'd15});
    idle(2);

    // Flush at RUN cycle 10 keeps the 3*5 result
    step(1'b1, 32'd7, 32'd9, 1'b0, 1'b0);
    idle(10);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("flush_idle", {78'd0, busy, done}, 80'd0);
    chk("flush_hilo", {16'd0, hi_out, lo_out}, {16'd0, 32'd0, 32'd15});
    idle(40);

    // Maximum operands
    step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_done(1'b0, n);
    chk("max_hilo", {16'd0, hi_out, lo_out}, {16'd0, 32'hFFFF_FFFE, 32'h0000_0001});
    idle(1);

    // Read interlock from RUN cycle 5
    a = 32'h1234_5678; b = 32'h9ABC_DEF0; p = 64'(a) * 64'(b);
    step(1'b1, a, b, 1'b0, 1'b0);
    idle(4);
    wait_done(1'b1, n);
    chk("interlock_stall_in_done", {79'd0, stall_req}, 80'd0);
    chk("interlock_hi", {48'd0, hi_out}, {48'd0, p[63:32]});
    idle(1);

    // Back-to-back: second start held until accepted in DONE
    step(1'b1, 32'd3, 32'd5, 1'b0, 1'b0);
    n = 0;
    do begin
      step(1'b1, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);
      n++;
    end while (!done && n < 200);
    chk("b2b_first_done", {79'd0, done}, 80'd1);
    wait_done(1'b0, n);
    chk("b2b_latency_steps", 80'(n), 80'(W + 1));
    chk("b2b_hilo", {16'd0, hi_out, lo_out}, {16'd0, 32'd1, 32'd0});
    idle(1);

    // Reset at RUN cycle 20
    step(1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 1'b0);
    idle(20);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("midrun_reset", {13'd0, busy, done, stall_req, hi_out, lo_out}, 80'd0);
    idle(2);
    @(posedge clk); #2 rst = 1'b1;
    idle(40);

    // Zero operand
    step(1'b1, 32'd0, 32'd7, 1'b0, 1'b0);
    wait_done(1'b0, n);
    chk("zero_latency_steps", 80'(n), ZSKIP ? 80'd1 : 80'(W + 1));
    chk("zero_hilo", {16'd0, hi_out, lo_out}, 80'd0);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      a = ($urandom % 8 == 0) ? 32'd0 : 32'($urandom);
      b = ($urandom % 8 == 0) ? 32'd0 : 32'($urandom);
      step(($urandom % 6) == 0, a, b, ($urandom % 4) == 0, ($urandom % 40) == 0);
    end
    idle(40);
    chk("scoreboard_drained", 80'(sb.size()), 80'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
